// File: rtl/restoring_division_reconstruct.sv
// Shift-add multiply-accumulate: dividend = quotient * divisor + remainder,
// one multiplier bit per cycle; the inverse of the restoring divider.
module restoring_division_reconstruct #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 src_valid,
  output logic                 src_ready,
  input  logic [WIDTH-1:0]     quotient,
  input  logic [WIDTH-1:0]     divisor,
  input  logic [WIDTH-1:0]     remainder,
  output logic                 dest_valid,
  input  logic                 dest_ready,
  output logic [2*WIDTH-1:0]   dividend,
  output logic [1:0]           state_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   dividend_q, dividend_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   acc_step;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; ready never depends combinationally on the opposite side, and
  // both are forced low while rst is high.
  assign src_ready  = (state_q == IDLE) && !rst;
  assign dest_valid = (state_q == DONE) && !rst;
  assign dividend   = dividend_q;
  assign state_o    = state_q;

  always_comb begin
    state_d    = state_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    dividend_d = dividend_q;
    cnt_d      = cnt_q;
    acc_step   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    case (state_q)
      IDLE: begin
        if (src_valid) begin
          mcand_d  = {{WIDTH{1'b0}}, divisor};
          mplier_d = quotient;
          acc_d    = {{WIDTH{1'b0}}, remainder};
          cnt_d    = '0;
          state_d  = CALC;
        end
      end
      CALC: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        // The last step's sum goes straight to the output register.
        if (cnt_q == CW'(WIDTH - 1)) begin
          dividend_d = acc_step;
          state_d    = DONE;
        end
      end
      DONE: begin
        if (dest_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      dividend_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      acc_q      <= acc_d;
      dividend_q <= dividend_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_restoring_division_reconstruct.sv
// Bench for restoring_division_reconstruct: directed cases plus random
// operands and stalls, checked every cycle against an arithmetic model.
module tb_restoring_division_reconstruct;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           src_valid;
  logic           src_ready;
  logic [W-1:0]   quotient, divisor, remainder;
  logic           dest_valid;
  logic           dest_ready;
  logic [2*W-1:0] dividend;
  logic [1:0]     dbg_state;

  int checks = 0;
  int errors = 0;

  // Clock / reset block
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  restoring_division_reconstruct #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .src_valid(src_valid), .src_ready(src_ready),
    .quotient(quotient), .divisor(divisor), .remainder(remainder),
    .dest_valid(dest_valid), .dest_ready(dest_ready),
    .dividend(dividend), .state_o(dbg_state)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard / behavioural model: an operation is pending from its accept
  // until its result handshake; its result is visible W cycles after accept.
  logic [2*W-1:0] exp_q[$];
  int             due_q[$];
  logic [2*W-1:0] model_div = '0;
  logic [2*W-1:0] last_out  = '0;
  int             hs_cnt    = 0;

  initial begin : compare
    bit pend, ripe, e_valid, e_ready;
    @(posedge clk);
    forever begin
      @(negedge clk);
      pend = (exp_q.size() != 0);
      ripe = 1'b0;
      if (pend) ripe = (cyc >= due_q[0]);
      if (ripe) model_div = exp_q[0];
      e_valid = !rst && ripe;
      e_ready = !rst && !pend;
      chk("src_ready", src_ready, e_ready);
      chk("dest_valid", dest_valid, e_valid);
      chk("dividend", dividend, model_div);
      if (rst) begin
        exp_q.delete();
        due_q.delete();
        model_div = '0;
      end else begin
        if (e_valid && dest_ready) begin
          last_out = dividend;
          hs_cnt++;
          void'(exp_q.pop_front());
          void'(due_q.pop_front());
        end
        if (e_ready && src_valid) begin
          exp_q.push_back((2*W)'(quotient) * (2*W)'(divisor) + (2*W)'(remainder));
          due_q.push_back(cyc + 1 + W);
        end
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic garble();
    src_valid = 1'($urandom_range(0, 1));
    quotient  = W'($urandom);
    divisor   = W'($urandom);
    remainder = W'($urandom);
  endtask

  task automatic send(input logic [W-1:0] q, input logic [W-1:0] d, input logic [W-1:0] r);
    int n;
    quotient  = q;
    divisor   = d;
    remainder = r;
    src_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!src_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("accept_timeout", 1, 0);
    tick();
    src_valid = 1'b0;
  endtask

  task automatic finish_op(input int stall);
    int n;
    dest_ready = (stall == 0);
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (dest_valid) break;
      tick();
      garble();
      n++;
    end
    if (n >= 200) begin
      chk("result_timeout", 1, 0);
      src_valid  = 1'b0;
      dest_ready = 1'b0;
      return;
    end
    repeat (stall) begin
      tick();
      garble();
    end
    if (stall > 0) dest_ready = 1'b1;
    tick();
    dest_ready = 1'b0;
    src_valid  = 1'b0;
  endtask

  task automatic run_op(input logic [W-1:0] q, input logic [W-1:0] d,
                        input logic [W-1:0] r, input int stall);
    send(q, d, r);
    finish_op(stall);
  endtask

  initial begin : stimulus
    logic [W-1:0]   q, d, r;
    logic [2*W-1:0] expv;
    rst = 1'b1; src_valid = 1'b0; dest_ready = 1'b0;
    quotient = '0; divisor = '0; remainder = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    run_op(16'd5, 16'd3, 16'd2, 0);
    chk("basic_17", last_out, 64'd17);
    run_op(16'hFFFF, 16'hFFFF, 16'hFFFF, 0);
    chk("max_ops", last_out, 64'hFFFF0000);
    run_op(16'h1234, 16'h0000, 16'h00AB, 1);
    chk("zero_divisor", last_out, 64'h000000AB);
    run_op(16'h0000, 16'hFFFF, 16'h0000, 0);
    chk("zero_quotient", last_out, 64'h0);
    run_op(16'd9, 16'd11, 16'd4, 10);
    chk("backpressure", last_out, 64'd103);

    // Reset in the middle of CALC
    send(16'd100, 16'd7, 16'd3);
    repeat (8) begin
      tick();
      garble();
    end
    rst = 1'b1;
    src_valid = 1'b0;
    @(negedge clk);
    chk("rst_src_ready", src_ready, 0);
    chk("rst_dest_valid", dest_valid, 0);
    tick();
    @(negedge clk);
    chk("rst_dividend", dividend, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", src_ready, 1);
    tick();
    run_op(16'd100, 16'd7, 16'd3, 2);
    chk("after_reset_703", last_out, 64'd703);

    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) begin
        tick();
        src_valid = 1'b0;
        quotient  = W'($urandom);
      end
      case ($urandom_range(0, 7))
        0: q = '0;
        1: q = '1;
        default: q = W'($urandom);
      endcase
      case ($urandom_range(0, 7))
        0: d = '0;
        1: d = '1;
        default: d = W'($urandom);
      endcase
      r = ($urandom_range(0, 7) == 0) ? '1 : W'($urandom);
      expv = (2*W)'(q) * (2*W)'(d) + (2*W)'(r);
      run_op(q, d, r, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0);
      chk("random_result", last_out, expv);
    end

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
